// File: rtl/kyber_pkg.sv
// Shared constants for the Kyber hash path: keccak mode codes, stream widths
// and the sequencer state encoding used by the keccak arbiter.
package kyber_pkg;

  localparam logic [1:0] KECCAK_SHAKE128 = 2'b00;
  localparam logic [1:0] KECCAK_SHAKE256 = 2'b01;
  localparam logic [1:0] KECCAK_SHA3_256 = 2'b10;
  localparam logic [1:0] KECCAK_SHA3_512 = 2'b11;

  localparam int IBYTES_LEN_W = 11;
  localparam int OBYTES_LEN_W = 10;
  localparam int WORD_W       = 64;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARB  = 2'd1,
    S_FWD  = 2'd2,
    S_REL  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/keccak_arb_rr_pick.sv
// Combinational round-robin priority encoder: the first requester after
// last_i (wrapping modulo NREQ) wins.
module rr_pick #(
  parameter int NREQ = 3,
  parameter int IDXW = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDXW-1:0] last_i,
  output logic [IDXW-1:0] win_o,
  output logic            any_o
);

  // Scan from the farthest offset down so the nearest candidate is assigned last.
  always_comb begin
    int idx;
    idx   = 0;
    win_o = '0;
    any_o = |req_i;
    for (int i = NREQ; i >= 1; i--) begin
      idx = (int'(last_i) + i) % NREQ;
      if (req_i[idx]) begin
        win_o = IDXW'(idx);
      end
    end
  end

endmodule

// File: rtl/keccak_arb.sv
// Round-robin owner of the single keccak core: grants one requester per hash,
// latches its mode/lengths, and routes both streams plus done to the owner only.
module keccak_arb
  import kyber_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int IDXW = 2
) (
  input  logic                           i_clk,
  input  logic                           i_rstn,
  input  logic [NREQ-1:0]                i_req,
  input  logic [2*NREQ-1:0]              i_mode,
  input  logic [WORD_W*NREQ-1:0]         i_ibytes,
  input  logic [NREQ-1:0]                i_ibytes_valid,
  input  logic [IBYTES_LEN_W*NREQ-1:0]   i_ibytes_len,
  input  logic [OBYTES_LEN_W*NREQ-1:0]   i_obytes_len,
  output logic [NREQ-1:0]                o_gnt,
  output logic [NREQ-1:0]                o_ibytes_ready,
  output logic [WORD_W-1:0]              o_obytes,
  output logic [NREQ-1:0]                o_obytes_valid,
  output logic [NREQ-1:0]                o_obytes_done,
  output logic                           o_busy,
  output logic [1:0]                     o_k_mode,
  output logic [WORD_W-1:0]              o_k_ibytes,
  output logic                           o_k_ibytes_valid,
  output logic [IBYTES_LEN_W-1:0]        o_k_ibytes_len,
  output logic [OBYTES_LEN_W-1:0]        o_k_obytes_len,
  input  logic                           i_k_ibytes_ready,
  input  logic [WORD_W-1:0]              i_k_obytes,
  input  logic                           i_k_obytes_valid,
  input  logic                           i_k_obytes_done
);

  arb_state_e              state_q, state_d;
  logic [IDXW-1:0]         gidx_q, gidx_d;
  logic [IDXW-1:0]         last_q, last_d;
  logic [NREQ-1:0]         gnt_q, gnt_d;
  logic                    busy_q, busy_d;
  logic [1:0]              k_mode_q, k_mode_d;
  logic [IBYTES_LEN_W-1:0] k_ilen_q, k_ilen_d;
  logic [OBYTES_LEN_W-1:0] k_olen_q, k_olen_d;

  logic [IDXW-1:0]         win;
  logic                    any_req;
  logic                    fwd;

  rr_pick #(
    .NREQ (NREQ),
    .IDXW (IDXW)
  ) u_rr_pick (
    .req_i  (i_req),
    .last_i (last_q),
    .win_o  (win),
    .any_o  (any_req)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_q  <= S_IDLE;
      gidx_q   <= '0;
      last_q   <= IDXW'(NREQ - 1);
      gnt_q    <= '0;
      busy_q   <= 1'b0;
      k_mode_q <= '0;
      k_ilen_q <= '0;
      k_olen_q <= '0;
    end else begin
      state_q  <= state_d;
      gidx_q   <= gidx_d;
      last_q   <= last_d;
      gnt_q    <= gnt_d;
      busy_q   <= busy_d;
      k_mode_q <= k_mode_d;
      k_ilen_q <= k_ilen_d;
      k_olen_q <= k_olen_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    gidx_d   = gidx_q;
    last_d   = last_q;
    gnt_d    = gnt_q;
    busy_d   = busy_q;
    k_mode_d = k_mode_q;
    k_ilen_d = k_ilen_q;
    k_olen_d = k_olen_q;
    case (state_q)
      S_IDLE: begin
        if (any_req) state_d = S_ARB;
      end
      S_ARB: begin
        if (any_req) begin
          gidx_d   = win;
          k_mode_d = i_mode[2*int'(win) +: 2];
          k_ilen_d = i_ibytes_len[IBYTES_LEN_W*int'(win) +: IBYTES_LEN_W];
          k_olen_d = i_obytes_len[OBYTES_LEN_W*int'(win) +: OBYTES_LEN_W];
          gnt_d    = NREQ'(1) << win;
          busy_d   = 1'b1;
          state_d  = S_FWD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FWD: begin
        // Grant and busy drop on entry to release so the bubble is grant-free.
        if (i_k_obytes_done) begin
          gnt_d   = '0;
          busy_d  = 1'b0;
          last_d  = gidx_q;
          state_d = S_REL;
        end
      end
      S_REL: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign fwd = (state_q == S_FWD);

  assign o_gnt            = gnt_q;
  assign o_busy           = busy_q;
  assign o_k_mode         = k_mode_q;
  assign o_k_ibytes_len   = k_ilen_q;
  assign o_k_obytes_len   = k_olen_q;
  assign o_k_ibytes       = fwd ? i_ibytes[WORD_W*int'(gidx_q) +: WORD_W] : '0;
  assign o_k_ibytes_valid = fwd & i_ibytes_valid[gidx_q];
  assign o_obytes         = fwd ? i_k_obytes : '0;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_route
      logic own;
      assign own                = fwd && (gidx_q == IDXW'(gi));
      assign o_ibytes_ready[gi] = own & i_k_ibytes_ready;
      assign o_obytes_valid[gi] = own & i_k_obytes_valid;
      assign o_obytes_done[gi]  = own & i_k_obytes_done;
    end
  endgenerate

endmodule

// File: tb/tb_keccak_arb.sv
// Directed bench for keccak_arb: table of single transactions plus hand-written
// round-robin and mid-transaction reset sequences; the bench plays the core.
module tb_keccak_arb;

  localparam int NREQ = 3;
  localparam int IDXW = 2;

  logic              clk = 1'b0;
  logic              i_rstn;
  logic [2:0]        i_req;
  logic [5:0]        i_mode;
  logic [191:0]      i_ibytes;
  logic [2:0]        i_ibytes_valid;
  logic [32:0]       i_ibytes_len;
  logic [29:0]       i_obytes_len;
  logic [2:0]        o_gnt, o_ibytes_ready, o_obytes_valid, o_obytes_done;
  logic [63:0]       o_obytes;
  logic              o_busy;
  logic [1:0]        o_k_mode;
  logic [63:0]       o_k_ibytes;
  logic              o_k_ibytes_valid;
  logic [10:0]       o_k_ibytes_len;
  logic [9:0]        o_k_obytes_len;
  logic              i_k_ibytes_ready;
  logic [63:0]       i_k_obytes;
  logic              i_k_obytes_valid;
  logic              i_k_obytes_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  keccak_arb #(.NREQ(NREQ), .IDXW(IDXW)) dut (
    .i_clk            (clk),
    .i_rstn           (i_rstn),
    .i_req            (i_req),
    .i_mode           (i_mode),
    .i_ibytes         (i_ibytes),
    .i_ibytes_valid   (i_ibytes_valid),
    .i_ibytes_len     (i_ibytes_len),
    .i_obytes_len     (i_obytes_len),
    .o_gnt            (o_gnt),
    .o_ibytes_ready   (o_ibytes_ready),
    .o_obytes         (o_obytes),
    .o_obytes_valid   (o_obytes_valid),
    .o_obytes_done    (o_obytes_done),
    .o_busy           (o_busy),
    .o_k_mode         (o_k_mode),
    .o_k_ibytes       (o_k_ibytes),
    .o_k_ibytes_valid (o_k_ibytes_valid),
    .o_k_ibytes_len   (o_k_ibytes_len),
    .o_k_obytes_len   (o_k_obytes_len),
    .i_k_ibytes_ready (i_k_ibytes_ready),
    .i_k_obytes       (i_k_obytes),
    .i_k_obytes_valid (i_k_obytes_valid),
    .i_k_obytes_done  (i_k_obytes_done)
  );

  typedef struct {
    logic       rst_before;
    logic [2:0] mask;
    int         r;
    logic [1:0] mode;
    int         ilen;
    int         olen;
    int         beats;
    logic       drop;
    logic       chg;
  } vec_t;

  vec_t vt[5];

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    i_rstn = 1'b0;
    i_req  = '0;
    repeat (2) @(negedge clk);
    i_rstn = 1'b1;
  endtask

  task automatic set_cfg(input int r, input logic [1:0] mode, input int ilen, input int olen);
    i_mode[2*r +: 2]        = mode;
    i_ibytes_len[11*r +: 11] = 11'(ilen);
    i_obytes_len[10*r +: 10] = 10'(olen);
  endtask

  task automatic wait_grant(output int cyc);
    cyc = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      cyc++;
      if (o_gnt != 0) break;
    end
  endtask

  // One full transaction from the grant cycle through release.
  task automatic serve(input int r, input logic [1:0] mode, input int ilen, input int olen,
                       input int beats, input logic drop, input logic chg, input logic keep);
    logic [2:0]  oh;
    logic [63:0] w;
    int n, got;
    oh = 3'b001 << r;
    chk("gnt", 80'(o_gnt), 80'(oh));
    chk("busy", 80'(o_busy), 80'(1));
    chk("k_mode", 80'(o_k_mode), 80'(mode));
    chk("k_ilen", 80'(o_k_ibytes_len), 80'(ilen));
    chk("k_olen", 80'(o_k_obytes_len), 80'(olen));
    if (drop) i_req[r] = 1'b0;
    if (chg) i_obytes_len[10*r +: 10] = 10'd200;
    w = 64'h1111_2222_0000_0000 + 64'(r);
    i_ibytes[64*r +: 64] = w;
    i_ibytes_valid   = 3'b111;
    i_k_ibytes_ready = 1'b1;
    #1;
    chk("in_fwd", {15'd0, o_k_ibytes_valid, o_k_ibytes}, {15'd0, 1'b1, w});
    chk("in_ready", 80'(o_ibytes_ready), 80'(oh));
    @(negedge clk);
    i_ibytes_valid   = '0;
    i_k_ibytes_ready = 1'b0;
    case (o_k_mode)
      2'b10:   n = 4;
      2'b11:   n = 8;
      default: n = (int'(o_k_obytes_len) + 7) / 8;
    endcase
    got = 0;
    for (int b = 0; b < n; b++) begin
      w = 64'hA5A5_0000_0000_0000 + 64'(b);
      i_k_obytes       = w;
      i_k_obytes_valid = 1'b1;
      #1;
      if (o_obytes_valid[r]) got++;
      chk("beat", {13'd0, o_obytes_valid, o_obytes}, {13'd0, oh, w});
      @(negedge clk);
    end
    i_k_obytes_valid = 1'b0;
    i_k_obytes_done  = 1'b1;
    #1;
    chk("done", 80'(o_obytes_done), 80'(oh));
    if (!keep) i_req[r] = 1'b0;
    @(negedge clk);
    i_k_obytes_valid = 1'b1;
    #1;
    chk("rel_gnt_busy", 80'({o_gnt, o_busy}), 80'(0));
    chk("rel_unrouted", 80'({o_obytes_valid, o_obytes_done, o_k_ibytes_valid}), 80'(0));
    @(negedge clk);
    i_k_obytes_valid = 1'b0;
    i_k_obytes_done  = 1'b0;
    chk("beats", 80'(got), 80'(beats));
    $display("txn req=%0d mode=%0d ilen=%0d olen=%0d beats=%0d", r, mode, ilen, olen, got);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    i_rstn = 1'b0; i_req = '0; i_mode = '0; i_ibytes = '0; i_ibytes_valid = '0;
    i_ibytes_len = '0; i_obytes_len = '0; i_k_ibytes_ready = 1'b0; i_k_obytes = '0;
    i_k_obytes_valid = 1'b0; i_k_obytes_done = 1'b0;

    vt[0] = '{1'b1, 3'b001, 0, 2'b00, 34, 168, 21, 1'b0, 1'b0};
    vt[1] = '{1'b1, 3'b011, 0, 2'b11, 33, 0,   8,  1'b0, 1'b0};
    vt[2] = '{1'b0, 3'b010, 1, 2'b10, 32, 0,   4,  1'b0, 1'b0};
    vt[3] = '{1'b0, 3'b100, 2, 2'b01, 20, 40,  5,  1'b1, 1'b0};
    vt[4] = '{1'b0, 3'b001, 0, 2'b00, 16, 32,  4,  1'b0, 1'b1};

    do_reset();
    #1;
    chk("rst_outs", 80'({o_gnt, o_busy, o_ibytes_ready, o_obytes_valid, o_obytes_done}), 80'(0));
    chk("rst_core", 80'({o_k_mode, o_k_ibytes_len, o_k_obytes_len, o_k_ibytes_valid}), 80'(0));
    $display("txn reset state");

    for (int i = 0; i < 5; i++) begin
      if (vt[i].rst_before) do_reset();
      set_cfg(vt[i].r, vt[i].mode, vt[i].ilen, vt[i].olen);
      if (i + 1 < 5 && vt[i+1].r != vt[i].r)
        set_cfg(vt[i+1].r, vt[i+1].mode, vt[i+1].ilen, vt[i+1].olen);
      i_req = vt[i].mask;
      wait_grant(cyc);
      chk("latency", 80'(cyc), 80'(2));
      serve(vt[i].r, vt[i].mode, vt[i].ilen, vt[i].olen, vt[i].beats,
            vt[i].drop, vt[i].chg, 1'b0);
    end

    // All three held: order 0,1,2,0,1,2 with a 3-cycle grant-free bubble each time.
    do_reset();
    for (int r = 0; r < 3; r++) set_cfg(r, 2'b10, 32, 0);
    i_req = 3'b111;
    for (int k = 0; k < 6; k++) begin
      wait_grant(cyc);
      chk("rr_latency", 80'(cyc), 80'(2));
      serve(k % 3, 2'b10, 32, 0, 4, 1'b0, 1'b0, 1'b1);
    end
    i_req = '0;

    // Reset during forwarding, then a fresh request to requester 1.
    set_cfg(0, 2'b00, 34, 64);
    i_req = 3'b001;
    wait_grant(cyc);
    chk("pre_rst_gnt", 80'(o_gnt), 80'(3'b001));
    @(negedge clk);
    i_rstn = 1'b0;
    i_req  = '0;
    @(negedge clk);
    #1;
    chk("mid_rst", 80'({o_gnt, o_busy, o_k_mode, o_k_obytes_len}), 80'(0));
    $display("txn mid-transaction reset");
    i_rstn = 1'b1;
    set_cfg(1, 2'b01, 16, 24);
    i_req = 3'b010;
    wait_grant(cyc);
    chk("post_rst_latency", 80'(cyc), 80'(2));
    serve(1, 2'b01, 16, 24, 3, 1'b0, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
